shared_reg_arb: RTL and testbench

- Round-robin arbiter and write sequencer for one shared W-bit data register; up to N requesters contend for it.
- A requester holds ownership while it keeps `req` asserted, capped at MAX_HOLD cycles when others are waiting.
- Registered one-hot grants; only the owner's write strobes reach the register.
- Sits between requester logic and the shared register bank; `q` is the register's output.

---
 rtl/shared_reg_arb_pkg.sv | 20 ++
 rtl/shared_reg_arb_rr_pick.sv | 27 ++
 rtl/shared_reg_arb.sv | 106 ++++++++++
 tb/tb_shared_reg_arb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and helpers for the shared-register round-robin arbiter.
// Holds the arbiter state encoding and the one-hot helper used by the top and the bench-facing ports.
package shared_reg_arb_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        RELEASE
    } state_e;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int unsigned cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// The owner keeps the grant while requesting, capped at MAX_HOLD cycles under contention.
module shared_reg_arb
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         wen,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [W-1:0]   q_q;
    logic [IW-1:0]  owner_q;
    logic [IW-1:0]  ptr_q;
    logic [HW-1:0]  hold_q;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic [N-1:0]   owner_oh;
    logic [N-1:0]   pick_oh;
    logic           owner_req;
    logic           owner_wen;
    logic [W-1:0]   owner_data;
    logic           others_pending;
    logic [IW-1:0]  ptr_next;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_oh       = N'(onehot(32'(owner_q)));
    assign pick_oh        = N'(onehot(32'(pick_idx)));
    assign owner_req      = req[owner_q];
    assign owner_wen      = wen[owner_q];
    assign owner_data     = wdata[owner_q*W +: W];
    assign others_pending = |(req & ~owner_oh);
    assign ptr_next       = (owner_q == IW'(N - 1)) ? '0 : IW'(owner_q + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        gnt_q   <= pick_oh;
                        hold_q  <= '0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    // The final-cycle write is kept even when the grant is being released.
                    if (owner_req && owner_wen) begin
                        q_q <= owner_data;
                    end
                    if (!owner_req || (hold_q == HOLD_LAST && others_pending)) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                        ptr_q   <= ptr_next;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arb.sv
// Bench for shared_reg_arb: directed scenarios plus randomized traffic against a grant-level model.
module tb_shared_reg_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   wen;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy;

    int compared   = 0;
    int mismatched = 0;

    // Model: owner index (-1 = nobody), grant cycles already served, dead-cycle flag.
    int         m_owner;
    int         m_last;
    int         m_ptr;
    int         m_held;
    bit         m_rel;
    logic [W-1:0] m_q;

    always #5 clk = ~clk;

    shared_reg_arb #(
        .N        (N),
        .W        (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wen   (wen),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_rel   = 1'b0;
        m_q     = '0;
    endfunction

    function automatic void model_step();
        bit others;
        bit found;
        int o;
        if (m_owner >= 0) begin
            o = m_owner;
            if (req[o] && wen[o]) m_q = wdata[o*W +: W];
            others = 1'b0;
            for (int j = 0; j < N; j++) if (j != o && req[j]) others = 1'b1;
            if (!req[o] || (m_held >= MH && others)) begin
                m_ptr   = (o + 1) % N;
                m_owner = -1;
                m_rel   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                o = (m_ptr + k) % N;
                if (!found && req[o]) begin
                    found   = 1'b1;
                    m_owner = o;
                    m_last  = o;
                    m_held  = 1;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("gnt",   32'(gnt),   32'(eg));
        check("q",     32'(q),     32'(m_q));
        check("owner", 32'(owner), 32'(m_last));
        check("busy",  32'(busy),  32'(m_owner >= 0 || m_rel));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_step();
        check_all();
    endtask

    task automatic randomize_inputs();
        req   = N'($urandom);
        wen   = N'($urandom);
        wdata = {$urandom};
    endtask

    task automatic reset_pulse();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            randomize_inputs();
            tick();
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        randomize_inputs();
        model_reset();
        #1;
        check("rst_gnt",  32'(gnt),   32'h0);
        check("rst_q",    32'(q),     32'h0);
        check("rst_busy", 32'(busy),  32'h0);
        check("rst_own",  32'(owner), 32'h0);
        repeat (3) begin
            randomize_inputs();
            tick();
        end
        @(negedge clk);
        rst = 1'b1;

        // Single write from requester 0.
        req   = 4'b0001;
        wen   = 4'b0001;
        wdata = {$urandom};
        wdata[7:0] = 8'hA5;
        tick();
        check("sw_gnt1", 32'(gnt), 32'h1);
        tick();
        check("sw_q2", 32'(q), 32'hA5);
        tick();
        req = '0;
        wen = '0;
        tick();
        check("sw_gnt4", 32'(gnt), 32'h0);
        check("sw_busy4", 32'(busy), 32'h1);
        tick();
        check("sw_busy5", 32'(busy), 32'h0);

        // Full contention rotation from a fresh pointer.
        reset_pulse();
        req = 4'b1111;
        wen = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                tick();
                check("rot_gnt", 32'(gnt), (c < 4) ? (32'h1 << (r % 4)) : 32'h0);
            end
        end

        // Sole requester never loses ownership.
        req = 4'b0100;
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            check("solo_gnt", 32'(gnt), 32'h4);
        end

        // Non-owner write strobe is ignored.
        req = '0;
        tick();
        tick();
        tick();
        req = 4'b0001;
        tick();
        check("no_gnt", 32'(gnt), 32'h1);
        begin
            logic [W-1:0] q_before;
            q_before = m_q;
            wen   = 4'b0100;
            wdata = {$urandom};
            wdata[23:16] = 8'h3C;
            tick();
            check("no_q_kept", 32'(q), 32'(q_before));
        end
        wen = 4'b0001;
        wdata[7:0] = 8'h5A;
        tick();
        check("no_q_5a", 32'(q), 32'h5A);

        // Asynchronous reset while requester 2 owns and writes.
        req = '0;
        wen = '0;
        tick();
        tick();
        tick();
        req = 4'b0100;
        wen = 4'b0100;
        wdata[23:16] = 8'hC3;
        tick();
        tick();
        check("mr_q", 32'(q), 32'hC3);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("mr_gnt0", 32'(gnt), 32'h0);
        check("mr_q0",   32'(q),   32'h0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0010;
        wen = '0;
        tick();
        check("mr_owner", 32'(owner), 32'h1);
        check("mr_gnt",   32'(gnt),   32'h2);

        // Randomized traffic with level-like requests and occasional resets.
        for (int c = 0; c < 600; c++) begin
            for (int j = 0; j < N; j++) if ($urandom_range(0, 5) == 0) req[j] = ~req[j];
            wen   = N'($urandom);
            wdata = {$urandom};
            if ($urandom_range(0, 149) == 0) reset_pulse();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
